// File: rtl/output_expand.sv
// Re-expands a tile's compact owned-channel stream to total_ochan beats per pixel, filling non-owned channels.
// One-cycle output register (zero latency when the tile owns every channel); ready_i low holds register and counter.
module output_expand #(
  parameter int              qw          = 8,
  parameter int              total_ochan = 8,
  parameter int              start_ochan = 0,
  parameter int              end_ochan   = 8,
  parameter logic [qw-1:0]   FILL        = '0
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic [qw-1:0] data_i,
  input  logic          valid_i,
  output logic          ready_o,
  output logic [qw-1:0] data_o,
  output logic          valid_o,
  input  logic          ready_i,
  output logic          last_o
);

  localparam int CW = (total_ochan > 1) ? $clog2(total_ochan) : 1;
  localparam logic [CW-1:0] LAST_C = CW'(total_ochan - 1);
  localparam bit TRANSP = ((end_ochan - start_ochan) == total_ochan);

  logic [CW-1:0] och_cnt;
  logic          out_vld;
  logic          out_last;
  logic [qw-1:0] out_data;

  logic load_en;
  logic in_win;
  logic load;
  logic cnt_wrap;
  logic cnt_adv;

  always_comb begin
    load_en  = ~out_vld | ready_i;
    in_win   = (int'(och_cnt) >= start_ochan) && (int'(och_cnt) < end_ochan);
    load     = load_en & (in_win ? valid_i : 1'b1);
    cnt_wrap = (och_cnt == LAST_C);
    // In transparent mode the counter only tracks accepted beats to generate last_o.
    cnt_adv  = TRANSP ? (valid_i & ready_i) : load;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      och_cnt  <= '0;
      out_vld  <= 1'b0;
      out_data <= '0;
      out_last <= 1'b0;
    end else begin
      if (cnt_adv) begin
        och_cnt <= cnt_wrap ? '0 : och_cnt + CW'(1);
      end
      if (load) begin
        out_vld  <= 1'b1;
        out_data <= in_win ? data_i : FILL;
        out_last <= cnt_wrap;
      end else if (load_en) begin
        out_vld  <= 1'b0;
      end
    end
  end

  assign ready_o = TRANSP ? ready_i : (load_en & in_win);
  assign data_o  = TRANSP ? data_i  : out_data;
  assign valid_o = TRANSP ? valid_i : out_vld;
  assign last_o  = TRANSP ? cnt_wrap : out_last;

endmodule

// File: tb/tb_output_expand.sv
// Directed bench for output_expand: three configurations share one input stream, outputs muxed by sel.
module tb_output_expand;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic [7:0] data_i = 8'h00;
  logic       valid_i = 1'b0;
  logic       ready_i = 1'b1;

  logic [7:0] a_dat, b_dat, c_dat;
  logic       a_vld, b_vld, c_vld;
  logic       a_rdy, b_rdy, c_rdy;
  logic       a_last, b_last, c_last;

  logic [7:0] obs_dat;
  logic       obs_vld, obs_rdy, obs_last;

  int sel = 0;
  int checks = 0;
  int failures = 0;

  logic [7:0] q[$];
  logic [8:0] got[$];
  logic [8:0] exp_q[$];
  logic       fire = 1'b0;
  logic       rnd_rdy = 1'b0;
  logic       prev_stall = 1'b0;
  logic [7:0] prev_dat = 8'h00;
  logic [7:0] dummy;

  always #5 clk = ~clk;

  output_expand #(.qw(8), .total_ochan(8), .start_ochan(2), .end_ochan(5), .FILL(8'h00)) u_a (
    .clk(clk), .rstn(rstn), .data_i(data_i), .valid_i(valid_i), .ready_o(a_rdy),
    .data_o(a_dat), .valid_o(a_vld), .ready_i(ready_i), .last_o(a_last));

  output_expand #(.qw(8), .total_ochan(4), .start_ochan(0), .end_ochan(1), .FILL(8'hFF)) u_b (
    .clk(clk), .rstn(rstn), .data_i(data_i), .valid_i(valid_i), .ready_o(b_rdy),
    .data_o(b_dat), .valid_o(b_vld), .ready_i(ready_i), .last_o(b_last));

  output_expand #(.qw(8), .total_ochan(4), .start_ochan(0), .end_ochan(4), .FILL(8'h00)) u_c (
    .clk(clk), .rstn(rstn), .data_i(data_i), .valid_i(valid_i), .ready_o(c_rdy),
    .data_o(c_dat), .valid_o(c_vld), .ready_i(ready_i), .last_o(c_last));

  always_comb begin
    obs_dat = a_dat; obs_vld = a_vld; obs_rdy = a_rdy; obs_last = a_last;
    if (sel == 1) begin
      obs_dat = b_dat; obs_vld = b_vld; obs_rdy = b_rdy; obs_last = b_last;
    end else if (sel == 2) begin
      obs_dat = c_dat; obs_vld = c_vld; obs_rdy = c_rdy; obs_last = c_last;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rstn = 1'b0;
    valid_i = 1'b0;
    data_i = 8'h00;
    ready_i = 1'b1;
    rnd_rdy = 1'b0;
    fire = 1'b0;
    prev_stall = 1'b0;
    q.delete();
    got.delete();
    repeat (2) @(negedge clk);
    rstn = 1'b1;
  endtask

  // Drive at posedge+1, observe at negedge; records every output transfer as {last, data}.
  task automatic run(input int ncyc);
    for (int c = 0; c < ncyc; c++) begin
      @(posedge clk); #1;
      if (fire) dummy = q.pop_front();
      if (q.size() > 0) begin
        valid_i = 1'b1;
        data_i = q[0];
      end else begin
        valid_i = 1'b0;
        data_i = 8'h00;
      end
      ready_i = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge clk);
      if (prev_stall) begin
        chk("hold_vld", 32'(obs_vld), 32'd1);
        chk("hold_dat", 32'(obs_dat), 32'(prev_dat));
      end
      if (obs_vld && !ready_i) chk("stall_rdy", 32'(obs_rdy), 32'd0);
      if (sel == 2) begin
        chk("pass_vld", 32'(obs_vld), 32'(valid_i));
        chk("pass_rdy", 32'(obs_rdy), 32'(ready_i));
        if (valid_i) chk("pass_dat", 32'(obs_dat), 32'(data_i));
      end
      prev_stall = obs_vld && !ready_i;
      prev_dat = obs_dat;
      if (obs_vld && ready_i) got.push_back({obs_last, obs_dat});
      fire = valid_i && obs_rdy;
    end
  endtask

  task automatic cmp_seq(input string tag);
    chk($sformatf("%s_len", tag), 32'(got.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got.size(); i++)
      chk($sformatf("%s[%0d]", tag, i), 32'(got[i]), 32'(exp_q[i]));
  endtask

  initial begin
    int cyc;

    // Reset state
    #12;
    chk("rst_vld", 32'(a_vld), 32'd0);
    chk("rst_dat", 32'(a_dat), 32'd0);
    chk("rst_last", 32'(a_last), 32'd0);
    chk("rst_rdy", 32'(a_rdy), 32'd0);

    // Basic expand: 8/2/5, inputs A,B,C
    sel = 0;
    do_reset();
    q = {8'h0A, 8'h0B, 8'h0C};
    run(1);
    chk("first_vld", 32'(got.size()), 32'd1);
    run(7);
    exp_q = {9'h000, 9'h000, 9'h00A, 9'h00B, 9'h00C, 9'h000, 9'h000, 9'h100};
    cmp_seq("basic");

    // Multi-pixel wrap: inputs 1..6
    do_reset();
    q = {8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
    run(16);
    exp_q = {9'h000, 9'h000, 9'h001, 9'h002, 9'h003, 9'h000, 9'h000, 9'h100,
             9'h000, 9'h000, 9'h004, 9'h005, 9'h006, 9'h000, 9'h000, 9'h100};
    cmp_seq("wrap");

    // Random backpressure: same output sequence as basic
    do_reset();
    q = {8'h0A, 8'h0B, 8'h0C};
    rnd_rdy = 1'b1;
    cyc = 0;
    while (got.size() < 8 && cyc < 300) begin
      run(1);
      cyc++;
    end
    rnd_rdy = 1'b0;
    exp_q = {9'h000, 9'h000, 9'h00A, 9'h00B, 9'h00C, 9'h000, 9'h000, 9'h100};
    cmp_seq("bp");

    // Input starvation: two leading fills then wait at channel 2
    do_reset();
    run(4);
    chk("starve_len", 32'(got.size()), 32'd2);
    chk("starve_vld", 32'(obs_vld), 32'd0);
    chk("starve_rdy", 32'(obs_rdy), 32'd1);
    q.push_back(8'h07);
    run(2);
    chk("starve_len2", 32'(got.size()), 32'd3);
    if (got.size() >= 3) chk("starve_dat", 32'(got[2]), 32'h007);

    // Edge window 4/0/1 FILL=FF
    sel = 1;
    do_reset();
    q = {8'h11};
    run(6);
    exp_q = {9'h011, 9'h0FF, 9'h0FF, 9'h1FF};
    cmp_seq("edge");

    // Transparent 4/0/4
    sel = 2;
    do_reset();
    q = {8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
    run(10);
    exp_q = {9'h001, 9'h002, 9'h003, 9'h104, 9'h005, 9'h006, 9'h007, 9'h108};
    cmp_seq("transp");

    // Reset mid-pixel
    sel = 0;
    do_reset();
    q = {8'h0A, 8'h0B, 8'h0C};
    run(3);
    chk("mid_len", 32'(got.size()), 32'd3);
    @(posedge clk); #2;
    rstn = 1'b0;
    #1;
    chk("mid_rst_vld", 32'(a_vld), 32'd0);
    chk("mid_rst_dat", 32'(a_dat), 32'd0);
    chk("mid_rst_last", 32'(a_last), 32'd0);
    do_reset();
    q = {8'h0A, 8'h0B, 8'h0C};
    run(8);
    exp_q = {9'h000, 9'h000, 9'h00A, 9'h00B, 9'h00C, 9'h000, 9'h000, 9'h100};
    cmp_seq("mid_restart");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/output_expand.md
Name: output_expand

Overview:
- Counterpart to the tile's input channel mask. A tile owns a slice [start_ochan, end_ochan) of a total_ochan-wide channel stream.
- This block takes the tile's compact output stream (one beat per owned channel) and re-expands it to the full total_ochan beats per pixel. It inserts FILL beats at the channel positions the tile does not own.
- It sits at the tile output, before the merge/accumulate network, and presents a full-channel-order stream downstream.

Parameters:
- total_ochan, 0, channels per pixel in the full stream; must be ≥1.
- start_ochan, 0, first owned channel index (inclusive).
- end_ochan, 0, owned channel bound (exclusive); 0 ≤ start_ochan < end_ochan ≤ total_ochan.
- FILL, 0, `QW-bit value emitted on non-owned channel positions.

Ports:
- clk  input  1  clock.
- rstn  input  1  asynchronous active-low reset.
- data_i  input  `QW  compact stream data, owned channels in ascending order.
- valid_i  input  1  data_i valid.
- ready_o  output  1  block accepts data_i.
- data_o  output  `QW  full-stream data.
- valid_o  output  1  data_o valid.
- ready_i  input  1  downstream accepts data_o.
- last_o  output  1  qualifies data_o; high on channel total_ochan-1 of each pixel.

Behaviour:
- Interface: one clock clk; reset rstn is asynchronous and active-low.
- Handshake: valid/ready on both sides. A transfer occurs when valid & ready are high on the same clk edge. valid_o and data_o hold stable while valid_o=1 & ready_i=0.
- Transparent mode (end_ochan-start_ochan == total_ochan): data_o=data_i, valid_o=valid_i, ready_o=ready_i. last_o comes from a beat counter identical to the one in expand mode. Zero latency.
- Expand mode:
  - Channel counter och_cnt has width $clog2(total_ochan), minimum 1 bit.
  - One output register {out_vld, out_data, out_last}.
  - load_en = ~out_vld | ready_i.
  - in_win = (och_cnt ≥ start_ochan) & (och_cnt < end_ochan).
  - ready_o = load_en & in_win. Input is consumed only in-window.
  - Load occurs when load_en & (in_win ? valid_i : 1):
    - out_data ← in_win ? data_i : FILL.
    - out_last ← (och_cnt == total_ochan-1).
    - out_vld ← 1.
    - och_cnt wraps to 0 after total_ochan-1, else increments.
  - If load_en with no load: out_vld ← 0.
  - Latency: exactly 1 cycle from input accept to valid_o.
  - Sustained throughput: 1 beat/cycle with ready_i=1. Fill beats are generated back-to-back without waiting on valid_i.
- Fill generation does not depend on valid_i. After the last owned channel of a pixel, the trailing fills and the next pixel's leading fills are emitted before the block stalls for the next owned input.
- Backpressure: out_vld & ~ready_i blocks loading. ready_o=0, and och_cnt and the output register hold.
- Simultaneous drain and load (out_vld & ready_i & new beat available): the register is replaced in the same edge with no bubble.
- Wrap-around: after och_cnt=total_ochan-1 is loaded, the next beat is channel 0 of the next pixel, whether fill or owned.
- Reset values, async on rstn low, including mid-pixel:
  - valid_o=0, data_o=0, last_o=0.
  - och_cnt=0, out_vld=0.
  - The partially emitted pixel is discarded; the first post-reset beat is channel 0.
- Edge windows:
  - start_ochan=0: no leading fills.
  - end_ochan=total_ochan: no trailing fills.
- ready_o never asserts on a non-owned position.

Test Plan:
- Basic expand: total=8, start=2, end=5, FILL=0, ready_i=1; inputs 0xA,0xB,0xC back-to-back -> data_o 0,0,0xA,0xB,0xC,0,0,0 on consecutive cycles; last_o only on the 8th beat; first valid_o 1 cycle after reset release.
- Multi-pixel wrap: same config, 6 inputs 1..6 -> 16 beats: 0,0,1,2,3,0,0,0,0,0,4,5,6,0,0,0; och_cnt returns to 0 after each 8th beat.
- Backpressure: random ready_i (50%), same config -> identical output sequence as the basic case; data_o stable while valid_o & ~ready_i; no input consumed while stalled.
- Input starvation: valid_i held low -> leading fills 0,0 emitted, then valid_o drops and ready_o=1 waits at channel 2; one input 0x7 -> 0x7 emitted next cycle.
- Edge window and transparent: total=4, start=0, end=1, FILL=0xFF, input 0x11 -> 0x11,0xFF,0xFF,0xFF. total=4, start=0, end=4 -> outputs equal inputs in the same cycle, last_o on every 4th beat.
- Reset mid-pixel: assert rstn low after 3 output beats -> valid_o=0 immediately; after release, inputs 0xA.. -> sequence restarts at channel 0 (0,0,0xA,...).
